// File: rtl/bomb_pkg.sv
// rtl/bomb_pkg.sv - shared game_state encodings and helpers for the bomb game stages
package bomb_pkg;

    typedef enum logic [7:0] {
        GS_IDLE     = 8'h00,
        GS_ARMED    = 8'h10,
        GS_DEFUSED  = 8'h20,
        GS_EXPLODED = 8'h30
    } game_state_t;

    function automatic logic [3:0] popcount8(input logic [7:0] v);
        logic [3:0] n;
        n = 4'd0;
        for (int i = 0; i < 8; i++) begin
            n = n + {3'd0, v[i]};
        end
        return n;
    endfunction

endpackage

// File: rtl/bomb_controller_if.sv
// rtl/bomb_controller_if.sv - game bus between puzzle/countdown stages and the bomb controller
interface bomb_if #(
    parameter int NUM_MODULES = 4
);
    logic                   start;
    logic [3:0]             value_three;
    logic [3:0]             value_two;
    logic [3:0]             value_one;
    logic [NUM_MODULES-1:0] module_solved;
    logic [NUM_MODULES-1:0] strike;
    logic [7:0]             game_state;
    logic [2:0]             strike_count;
    logic                   timer_zero;

    modport master (
        output start, value_three, value_two, value_one, module_solved, strike,
        input  game_state, strike_count, timer_zero
    );

    modport slave (
        input  start, value_three, value_two, value_one, module_solved, strike,
        output game_state, strike_count, timer_zero
    );
endinterface

// File: rtl/bomb_controller_strike_accum.sv
// rtl/bomb_controller_strike_accum.sv - saturating strike tally with clear and enable
module strike_accum
    import bomb_pkg::*;
#(
    parameter int NUM_MODULES = 4,
    parameter int MAX_STRIKES = 3
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   clear,
    input  logic                   enable,
    input  logic [NUM_MODULES-1:0] strike,
    output logic [2:0]             count,
    output logic [2:0]             count_next
);
    localparam logic [4:0] MAX_W = 5'(MAX_STRIKES);

    logic [7:0] strike_w;
    logic [4:0] sum;

    assign strike_w   = 8'(strike);
    assign sum        = {2'b00, count} + {1'b0, popcount8(strike_w)};
    assign count_next = (sum >= MAX_W) ? MAX_W[2:0] : sum[2:0];

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            count <= 3'd0;
        end else if (enable) begin
            count <= count_next;
        end
    end
endmodule

// File: rtl/bomb_controller.sv
// rtl/bomb_controller.sv - game-level FSM deciding armed/defused/exploded from timer, solves and strikes
module bomb_controller
    import bomb_pkg::*;
#(
    parameter int NUM_MODULES = 4,
    parameter int MAX_STRIKES = 3,
    parameter int ZERO_GUARD  = 2
) (
    input  logic clk,
    input  logic reset,
    bomb_if.slave bus
);
    localparam logic [7:0] GUARD_MAX = 8'(ZERO_GUARD);
    localparam logic [2:0] MAX_W     = 3'(MAX_STRIKES);

    game_state_t state, state_next;
    logic        start_q, start_rise, all_zero, timer_zero_q;
    logic        acc_clear, acc_enable;
    logic [7:0]  guard;
    logic [2:0]  count, count_next;

    assign start_rise = bus.start & ~start_q;
    assign all_zero   = (bus.value_three == 4'd0) && (bus.value_two == 4'd0) && (bus.value_one == 4'd0);

    strike_accum #(
        .NUM_MODULES(NUM_MODULES),
        .MAX_STRIKES(MAX_STRIKES)
    ) u_strike_accum (
        .clk       (clk),
        .reset     (reset),
        .clear     (acc_clear),
        .enable    (acc_enable),
        .strike    (bus.strike),
        .count     (count),
        .count_next(count_next)
    );

    // Explosion is checked before defuse so a coinciding final strike still wins.
    always_comb begin
        state_next = state;
        acc_clear  = 1'b0;
        acc_enable = 1'b0;
        case (state)
            GS_IDLE: begin
                if (start_rise) begin
                    state_next = GS_ARMED;
                    acc_clear  = 1'b1;
                end
            end
            GS_ARMED: begin
                acc_enable = 1'b1;
                if ((count_next == MAX_W) || timer_zero_q) begin
                    state_next = GS_EXPLODED;
                end else if (&bus.module_solved) begin
                    state_next = GS_DEFUSED;
                end
            end
            GS_DEFUSED, GS_EXPLODED: begin
                if (start_rise) begin
                    state_next = GS_IDLE;
                    acc_clear  = 1'b1;
                end
            end
            default: state_next = GS_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= GS_IDLE;
            start_q      <= 1'b0;
            guard        <= 8'd0;
            timer_zero_q <= 1'b0;
        end else begin
            state        <= state_next;
            start_q      <= bus.start;
            timer_zero_q <= all_zero && (guard == GUARD_MAX) && (state == GS_ARMED);
            // The guard gives the countdown time to load before 000 counts as a timeout.
            if (state == GS_IDLE && start_rise) begin
                guard <= 8'd0;
            end else if (state == GS_ARMED && guard != GUARD_MAX) begin
                guard <= guard + 8'd1;
            end
        end
    end

    assign bus.game_state   = state;
    assign bus.strike_count = count;
    assign bus.timer_zero   = timer_zero_q;
endmodule

// File: tb/tb_bomb_controller.sv
// tb/tb_bomb_controller.sv - directed and randomized checks of bomb_controller against a reference model
module tb_bomb_controller;
    localparam int NM = 4;
    localparam int MS = 3;
    localparam int ZG = 2;

    logic clk;
    logic reset;
    int   errors;
    int   checks;

    int   m_state;
    int   m_cnt;
    int   m_guard;
    bit   m_tz;
    bit   m_sq;

    bomb_if #(.NUM_MODULES(NM)) bus ();

    bomb_controller #(
        .NUM_MODULES(NM),
        .MAX_STRIKES(MS),
        .ZERO_GUARD (ZG)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_update();
        int  pop;
        int  nxt;
        bit  rise;
        bit  new_tz;
        pop  = $countones(bus.strike);
        rise = bus.start && !m_sq;
        if (reset) begin
            m_state = 'h00; m_cnt = 0; m_guard = 0; m_tz = 0; m_sq = 0;
        end else begin
            new_tz = (bus.value_three == 0) && (bus.value_two == 0) && (bus.value_one == 0)
                     && (m_guard == ZG) && (m_state == 'h10);
            case (m_state)
                'h00: if (rise) begin m_state = 'h10; m_cnt = 0; m_guard = 0; end
                'h10: begin
                    nxt = (m_cnt + pop > MS) ? MS : m_cnt + pop;
                    m_cnt = nxt;
                    if (m_guard < ZG) m_guard = m_guard + 1;
                    if (nxt == MS || m_tz) m_state = 'h30;
                    else if (bus.module_solved == {NM{1'b1}}) m_state = 'h20;
                end
                default: if (rise) begin m_state = 'h00; m_cnt = 0; end
            endcase
            m_tz = new_tz;
            m_sq = bus.start;
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_update();
        #1;
        chk("model_game_state", bus.game_state, 8'(m_state));
        chk("model_strike_count", {5'd0, bus.strike_count}, 8'(m_cnt));
        chk("model_timer_zero", {7'd0, bus.timer_zero}, {7'd0, m_tz});
    endtask

    task automatic digits(input int a, input int b, input int c);
        bus.value_three = 4'(a);
        bus.value_two   = 4'(b);
        bus.value_one   = 4'(c);
    endtask

    task automatic pulse_start();
        bus.start = 1'b1; step();
        bus.start = 1'b0; step();
    endtask

    initial begin
        errors = 0; checks = 0;
        m_state = 0; m_cnt = 0; m_guard = 0; m_tz = 0; m_sq = 0;
        reset = 1'b1;
        bus.start = 1'b0; bus.module_solved = '0; bus.strike = '0;
        digits(0, 0, 0);
        step(); step();
        chk("reset_state", bus.game_state, 8'h00);
        chk("reset_count", {5'd0, bus.strike_count}, 8'd0);
        reset = 1'b0;

        // timeout path
        bus.start = 1'b1; step();
        chk("armed_after_start", bus.game_state, 8'h10);
        bus.start = 1'b0; digits(0, 0, 5);
        step(); step();
        chk("armed_through_guard", bus.game_state, 8'h10);
        for (int d = 4; d >= 1; d--) begin
            digits(0, 0, d); step();
        end
        digits(0, 0, 0); step();
        chk("timer_zero_set", {7'd0, bus.timer_zero}, 8'd1);
        chk("not_yet_exploded", bus.game_state, 8'h10);
        step();
        chk("timeout_explode", bus.game_state, 8'h30);

        // strike-limit path
        digits(1, 2, 0);
        pulse_start();
        chk("back_idle", bus.game_state, 8'h00);
        pulse_start();
        bus.strike = 4'b0001; step();
        chk("one_strike", {5'd0, bus.strike_count}, 8'd1);
        bus.strike = 4'b0110; step();
        bus.strike = 4'b0000;
        chk("three_strikes", {5'd0, bus.strike_count}, 8'd3);
        chk("strike_explode", bus.game_state, 8'h30);

        // defuse path
        pulse_start(); pulse_start();
        bus.module_solved = 4'b0001; step();
        bus.module_solved = 4'b0011; step();
        bus.module_solved = 4'b0111; step();
        chk("partial_solve", bus.game_state, 8'h10);
        bus.module_solved = 4'b1111; step();
        chk("defused", bus.game_state, 8'h20);
        bus.strike = 4'b0011; step();
        bus.strike = 4'b0000;
        chk("frozen_count", {5'd0, bus.strike_count}, 8'd0);

        // explode beats defuse in the same cycle
        bus.module_solved = 4'b0000;
        pulse_start(); pulse_start();
        bus.strike = 4'b0011; step();
        bus.strike = 4'b0001; bus.module_solved = 4'b1111; step();
        bus.strike = 4'b0000; bus.module_solved = 4'b0000;
        chk("explode_priority", bus.game_state, 8'h30);

        // held start yields one transition
        bus.start = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            chk("held_start_idle", bus.game_state, 8'h00);
            chk("held_start_count", {5'd0, bus.strike_count}, 8'd0);
        end
        bus.start = 1'b0; step();
        bus.start = 1'b1; step();
        bus.start = 1'b0;
        chk("rearmed", bus.game_state, 8'h10);

        // reset mid-game
        bus.strike = 4'b0101; step();
        bus.strike = 4'b0000;
        chk("two_strikes", {5'd0, bus.strike_count}, 8'd2);
        reset = 1'b1; bus.start = 1'b1; bus.strike = 4'b1111; step();
        chk("reset_mid_state", bus.game_state, 8'h00);
        chk("reset_mid_count", {5'd0, bus.strike_count}, 8'd0);
        chk("reset_mid_tz", {7'd0, bus.timer_zero}, 8'd0);
        reset = 1'b0; bus.start = 1'b0; bus.strike = 4'b0000; step();

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            reset = ($urandom_range(0, 299) == 0);
            if ($urandom_range(0, 7) == 0) bus.start = ~bus.start;
            for (int b = 0; b < NM; b++) begin
                bus.strike[b] = ($urandom_range(0, 14) == 0);
            end
            if ($urandom_range(0, 5) == 0) bus.module_solved[$urandom_range(0, NM - 1)] = 1'b1;
            if ($urandom_range(0, 40) == 0) bus.module_solved = '0;
            if ($urandom_range(0, 3) == 0) digits(0, 0, 0);
            else digits($urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 15));
            step();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/bomb_controller.md
Name: bomb_controller

Overview:
- Game-level FSM that drives the 8-bit game_state bus read by the countdown, puzzle-module and display stages.
- Consumes the three BCD countdown digits, per-module solved levels and per-module strike pulses.
- Decides ARMED, DEFUSED or EXPLODED, and keeps the strike tally.
- Sits directly downstream of the countdown stage and closes the loop back to it through game_state.

Parameters:
- NUM_MODULES, 4, number of puzzle modules, 1..8.
- MAX_STRIKES, 3, strike count that causes an explosion, 1..7.
- ZERO_GUARD, 2, cycles after entering ARMED during which timer-zero is ignored, so the countdown can load init_time.

Ports:
- clk  in  1  on-board 50 MHz clock.
- reset  in  1  synchronous, active-high reset.
- start  in  1  synchronised start/acknowledge button level, active high.
- value_three  in  4  countdown BCD digit, leftmost.
- value_two  in  4  countdown BCD digit, middle.
- value_one  in  4  countdown BCD digit, rightmost.
- module_solved  in  NUM_MODULES  level per module; 1 = solved.
- strike  in  NUM_MODULES  one-cycle pulse per module per wrong action.
- game_state  out  8  00 IDLE, 10 ARMED, 20 DEFUSED, 30 EXPLODED.
- strike_count  out  3  strikes accumulated this game, saturating.
- timer_zero  out  1  registered; 1 when all three digits are 0 and the guard has expired.

Behaviour:
- Fixed by decision: one clock; reset is synchronous and active-high. All state updates on posedge clk; no other async paths.
- Reset values: game_state=00, strike_count=0, timer_zero=0, guard counter=0, start_q=0.
- Start edge: start_rise = start & ~start_q, where start_q is the registered previous value. Holding start produces one event only.
- Popcount: number of strike bits set in a cycle, width 4.
- Strike accumulation: strike_count_next = min(strike_count + popcount, MAX_STRIKES). Applies only in ARMED; strikes in other states are ignored.
- Guard counter: cleared on ARMED entry; increments while in ARMED until it reaches ZERO_GUARD, then holds.
- timer_zero: registered as (digits==0,0,0) & (guard==ZERO_GUARD) & (state==ARMED).
- FSM, one transition per cycle, next-state registered. game_state output is the registered state encoding, so changes appear one cycle after the cause.
  - IDLE: start_rise -> ARMED, with strike_count cleared and guard cleared. Otherwise stay.
  - ARMED, priority order:
    1. explode = (strike_count_next == MAX_STRIKES) | timer_zero -> EXPLODED.
    2. else if &module_solved -> DEFUSED.
    3. else stay.
    - Explosion wins when it coincides with all-solved in the same cycle.
  - DEFUSED and EXPLODED: hold; strike_count frozen. start_rise -> IDLE, which clears strike_count on entry. The countdown drops to its init state on seeing 20/30.
- timer_zero is registered, so explosion on timeout lands 2 cycles after digits read 000 (one cycle for timer_zero, one for the state register).
- Strike-limit explosion is evaluated on strike_count_next, so it occurs in the same cycle the strike count saturates.
- Digits non-BCD (>9): treated as non-zero; no error flagged.
- Reset asserted in any state: next cycle is IDLE with all outputs at reset values, regardless of start/strike in that cycle.
- start_rise in ARMED: ignored. No abort.

Decomposition:
- Shared package bomb_pkg:
  - game_state encodings GS_IDLE=8'h00, GS_ARMED=8'h10, GS_DEFUSED=8'h20, GS_EXPLODED=8'h30.
  - Shared with the countdown and module blocks.
- One natural sub-module, strike_accum: popcount plus saturating adder plus strike_count register, with inputs clear and enable.
- Edge detect and guard counter stay inline.

Test Plan:
- Reset then start pulse with digits 0/0/0 and no solves -> game_state 10 and stays 10 through the guard. Digits to 0/0/5 then counting to 0/0/0 -> timer_zero=1 next cycle, game_state=30 the cycle after.
- ARMED, strike pulses 4'b0001 then 4'b0110 (MAX_STRIKES=3) -> strike_count 1 then 3; game_state=30 in the cycle strike_count reaches 3.
- ARMED, module_solved rises bit by bit to 4'b1111 with digits 1/2/0 -> game_state=20 one cycle after the last bit; later strike pulses leave strike_count unchanged.
- Same cycle: module_solved becomes 4'b1111 and strike_count reaches 3 -> game_state=30, not 20.
- In EXPLODED, start held high 10 cycles -> single transition to 00 with strike_count=0. A further start edge -> 10.
- Reset asserted mid-ARMED with strike_count=2 -> next cycle game_state=00, strike_count=0, timer_zero=0.
